// File: rtl/seq_addsub_if.sv
// Operand / result handshake bundle for seq_addsub.
// master drives operands and out_ready; slave returns result and flags.
interface seq_addsub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             ne;
    logic             lt;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, ne, lt
    );

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, ne, lt
    );
endinterface

// File: rtl/seq_addsub.sv
// Sequential WIDTH-bit add/sub, one SLICE-bit lookahead slice per cycle.
// Ports: clock, reset_n (async low), bus (slave: operands in, result+flags out).
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    seq_addsub_if.slave  bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ne_q;
    logic             lt_q;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic [SLICE-1:0] s;
    logic [WIDTH-1:0] res_d;
    logic             last;
    logic             ovf_d;

    // One slice of generate/propagate carry lookahead.
    always_comb begin
        sa   = a_q[int'(idx_q)*SLICE +: SLICE];
        sb   = b_q[int'(idx_q)*SLICE +: SLICE];
        g    = sa & sb;
        p    = sa ^ sb;
        c    = '0;
        c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s     = p ^ c[SLICE-1:0];
        res_d = result_q;
        res_d[int'(idx_q)*SLICE +: SLICE] = s;
        last  = (idx_q == IW'(N - 1));
        // On the top slice, c[SLICE-1] is the carry into the MSB.
        ovf_d = c[SLICE] ^ c[SLICE-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        // Subtract as A + ~B + 1.
                        b_q      <= bus.op_sub ? ~bus.b : bus.b;
                        carry_q  <= bus.op_sub;
                        idx_q    <= '0;
                        result_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= res_d;
                    carry_q  <= c[SLICE];
                    if (last) begin
                        cout_q  <= c[SLICE];
                        ovf_q   <= ovf_d;
                        ne_q    <= |res_d;
                        lt_q    <= res_d[WIDTH-1] ^ ovf_d;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.ne        = ne_q;
    assign bus.lt        = lt_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub against an arithmetic reference model.
// Directed, random, backpressure, back-to-back and mid-run reset scenarios.
module tb_seq_addsub;
    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    seq_addsub_if #(.WIDTH(32)) bus ();

    seq_addsub #(.WIDTH(32), .SLICE(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {result, cout, ovf, ne, lt} from true signed/unsigned arithmetic.
    function automatic logic [35:0] model(input bit op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      t;
        logic [32:0] us;
        logic [31:0] res;
        logic        co;
        logic        ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        t   = op ? sa - sb : sa + sb;
        us  = {1'b0, a} + {1'b0, b};
        co  = op ? (a >= b) : us[32];
        res = t[31:0];
        ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {res, co, ov, (res != 32'd0), (t < 0)};
    endfunction

    function automatic logic [35:0] observed();
        return {bus.result, bus.cout, bus.ovf, bus.ne, bus.lt};
    endfunction

    task automatic start_op(input bit op, input logic [31:0] a,
                            input logic [31:0] b);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.op_sub   = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.op_sub   = 1'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Edges from accept until out_valid; 99 if it never comes.
    task automatic wait_done(output int lat, input bit rnd_ready);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            if (rnd_ready) bus.out_ready = 1'($urandom);
            @(posedge clock); #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] got;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_sub    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clock);
        #1;
        got = {bus.in_ready, bus.out_valid, observed()};
        vectors++;
        if (got !== {2'b10, 36'h0}) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", got, {2'b10, 36'h0});
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        bit          ops[6] = '{0, 0, 0, 1, 1, 1};
        logic [31:0] as[6]  = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                32'h80000000, 32'd5, 32'd7};
        logic [31:0] bs[6]  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'd7, 32'd7};
        logic [35:0] exp;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            exp = model(ops[i], as[i], bs[i]);
            start_op(ops[i], as[i], bs[i]);
            wait_done(lat, 1'b0);
            vectors++;
            if (lat != 4) begin
                miscompares++;
                $display("FAIL dir_latency[%0d] got=%0d exp=4", i, lat);
            end
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL dir_result[%0d] got=%h exp=%h", i, observed(), exp);
            end
            release_out();
        end
        // Explicit anchor for the slice-boundary ripple case.
        start_op(1'b0, 32'h000000FF, 32'h1);
        wait_done(lat, 1'b0);
        vectors++;
        if (bus.result !== 32'h00000100) begin
            miscompares++;
            $display("FAIL ripple_anchor got=%h exp=00000100", bus.result);
        end
        release_out();
    endtask

    task automatic test_random();
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] exp;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 1'($urandom);
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            if (i % 7 == 0) b = {a[31], 31'($urandom_range(0, 3))};
            exp = model(op, a, b);
            start_op(op, a, b);
            wait_done(lat, 1'b1);
            vectors++;
            if (lat != 4 || observed() !== exp) begin
                miscompares++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h lat=%0d got=%h exp=%h",
                         i, op, a, b, lat, observed(), exp);
            end
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        logic [37:0] got;
        int          lat;
        exp = model(1'b1, 32'h12340000, 32'h00005678);
        start_op(1'b1, 32'h12340000, 32'h00005678);
        wait_done(lat, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            got = {bus.in_ready, bus.out_valid, observed()};
            vectors++;
            if (got !== {2'b01, exp}) begin
                miscompares++;
                $display("FAIL backpressure[%0d] got=%h exp=%h", k, got, {2'b01, exp});
            end
        end
        // Operands offered in the release cycle must wait one more edge.
        bus.in_valid  = 1'b1;
        bus.op_sub    = 1'b0;
        bus.a         = 32'd1;
        bus.b         = 32'd2;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL release got=%b exp=01", {bus.out_valid, bus.in_ready});
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        wait_done(lat, 1'b0);
        vectors++;
        if (lat != 4 || bus.result !== 32'd3) begin
            miscompares++;
            $display("FAIL back_to_back lat=%0d got=%h exp=00000003", lat, bus.result);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [37:0] got;
        int          lat;
        start_op(1'b0, 32'hAAAA5555, 32'h0F0F0F0F);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        got = {bus.in_ready, bus.out_valid, observed()};
        vectors++;
        if (got !== {2'b10, 36'h0}) begin
            miscompares++;
            $display("FAIL reset_mid got=%h exp=%h", got, {2'b10, 36'h0});
        end
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_valid got=%b exp=0", bus.out_valid);
        end
        start_op(1'b0, 32'h12345678, 32'h11111111);
        wait_done(lat, 1'b0);
        vectors++;
        if (lat != 4 || bus.result !== 32'h23456789) begin
            miscompares++;
            $display("FAIL after_reset lat=%0d got=%h exp=23456789", lat, bus.result);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
